// File: rtl/sync_fifo_mem.sv
// FIFO_DEPTH x DATA_WIDTH register file: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 50,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with active-low full/empty flags.
// Define FIFO_ASSERT_EN to compile in overflow/underflow simulation checks.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 50
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enq_i,
  input  logic                  deq_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o_n,
  output logic                  empty_o_n
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             enq_eff, deq_eff;

  assign full_o_n  = (count != CNT_FULL);
  assign empty_o_n = (count != '0);

  // A push while full is legal only when the same cycle frees the head slot.
  assign enq_eff = enq_i & (full_o_n | deq_i);
  assign deq_eff = deq_i & empty_o_n;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_eff) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (deq_eff) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      if (enq_eff && !deq_eff)      count <= count + 1'b1;
      else if (deq_eff && !enq_eff) count <= count - 1'b1;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (PTR_W)
  ) u_mem (
    .clk     (clk_i),
    .wr_en   (enq_eff & rst_n_i),
    .wr_addr (wr_ptr),
    .wr_data (din_i),
    .rd_addr (rd_ptr),
    .rd_data (dout_o)
  );

`ifdef FIFO_ASSERT_EN
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      if (enq_i && !full_o_n && !deq_i) $error("sync_fifo: overflow, enqueue while full");
      if (deq_i && !empty_o_n)          $error("sync_fifo: underflow, dequeue while empty");
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo at DEPTH=4 and DEPTH=50 (WIDTH=8).
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_enq, a_deq;
  logic [7:0] a_din, a_dout;
  logic       a_full_n, a_empty_n;

  logic       b_rst_n, b_enq, b_deq;
  logic [7:0] b_din, b_dout;
  logic       b_full_n, b_empty_n;

  int checks = 0;
  int errors = 0;

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut_a (
    .clk_i     (clk),
    .rst_n_i   (a_rst_n),
    .enq_i     (a_enq),
    .deq_i     (a_deq),
    .din_i     (a_din),
    .dout_o    (a_dout),
    .full_o_n  (a_full_n),
    .empty_o_n (a_empty_n)
  );

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(50)) dut_b (
    .clk_i     (clk),
    .rst_n_i   (b_rst_n),
    .enq_i     (b_enq),
    .deq_i     (b_deq),
    .din_i     (b_din),
    .dout_o    (b_dout),
    .full_o_n  (b_full_n),
    .empty_o_n (b_empty_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic a_push(input logic [7:0] d);
    a_enq = 1'b1; a_din = d; a_deq = 1'b0;
    step();
    a_enq = 1'b0;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; a_enq = 1'b0; a_deq = 1'b0; a_din = '0;
    b_rst_n = 1'b0; b_enq = 1'b0; b_deq = 1'b0; b_din = '0;
    step(); step();
    chk_bit("reset_empty_n", a_empty_n, 1'b0);
    chk_bit("reset_full_n", a_full_n, 1'b1);
    chk_bit("reset_b_empty_n", b_empty_n, 1'b0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    a_deq = 1'b1;
    step();
    a_deq = 1'b0;
    chk_bit("underflow_empty_n", a_empty_n, 1'b0);
    chk_bit("underflow_full_n", a_full_n, 1'b1);
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      a_push(vals[i]);
      chk_bit("fill_empty_n", a_empty_n, 1'b1);
      chk_bit("fill_full_n", a_full_n, (i == 3) ? 1'b0 : 1'b1);
    end
    chk_byte("fill_head", a_dout, 8'h11);
    a_push(8'h55);
    chk_bit("overflow_full_n", a_full_n, 1'b0);
    chk_byte("overflow_head", a_dout, 8'h11);
    for (int i = 0; i < 4; i++) begin
      chk_byte("drain_dout", a_dout, vals[i]);
      a_deq = 1'b1;
      step();
      a_deq = 1'b0;
      chk_bit("drain_full_n", a_full_n, 1'b1);
    end
    chk_bit("drained_empty_n", a_empty_n, 1'b0);
  endtask

  task automatic test_full_simul();
    logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    a_push(8'h11); a_push(8'h22); a_push(8'h33); a_push(8'h44);
    chk_bit("fs_full_n_before", a_full_n, 1'b0);
    chk_byte("fs_popped", a_dout, 8'h11);
    a_enq = 1'b1; a_deq = 1'b1; a_din = 8'h55;
    step();
    a_enq = 1'b0; a_deq = 1'b0;
    chk_bit("fs_full_n_after", a_full_n, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_byte("fs_drain_dout", a_dout, exp[i]);
      a_deq = 1'b1;
      step();
      a_deq = 1'b0;
    end
    chk_bit("fs_empty_n", a_empty_n, 1'b0);
  endtask

  task automatic test_empty_simul();
    a_enq = 1'b1; a_deq = 1'b1; a_din = 8'hA5;
    step();
    a_enq = 1'b0; a_deq = 1'b0;
    chk_byte("es_dout", a_dout, 8'hA5);
    chk_bit("es_empty_n", a_empty_n, 1'b1);
    chk_bit("es_full_n", a_full_n, 1'b1);
    // Count must be exactly 1: a single pop empties it.
    a_deq = 1'b1;
    step();
    a_deq = 1'b0;
    chk_bit("es_count_one", a_empty_n, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 50; i++) begin
      b_enq = 1'b1; b_din = 8'(i);
      step();
    end
    b_enq = 1'b0;
    chk_bit("wrap_full_n_filled", b_full_n, 1'b0);
    for (int i = 0; i < 120; i++) begin
      chk_byte("wrap_dout", b_dout, 8'(i % 50));
      b_enq = 1'b1; b_deq = 1'b1; b_din = b_dout;
      step();
      chk_bit("wrap_full_n", b_full_n, 1'b0);
    end
    b_enq = 1'b0; b_deq = 1'b0;
    chk_byte("wrap_final_dout", b_dout, 8'(120 % 50));
  endtask

  task automatic test_mid_reset();
    a_push(8'h01); a_push(8'h02); a_push(8'h03);
    chk_bit("mr_empty_n_before", a_empty_n, 1'b1);
    a_rst_n = 1'b0; a_enq = 1'b1; a_din = 8'hEE;
    step();
    a_rst_n = 1'b1; a_enq = 1'b0;
    chk_bit("mr_empty_n", a_empty_n, 1'b0);
    chk_bit("mr_full_n", a_full_n, 1'b1);
    a_push(8'h7E);
    chk_byte("mr_dout", a_dout, 8'h7E);
    chk_bit("mr_empty_n_after", a_empty_n, 1'b1);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_empty_simul();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
